// File: rtl/uart_sdram_bridge.sv
// uart_sdram_bridge: framed UART byte commands -> four-phase req/ack SDRAM word access -> UART reply.
// Latency: req 1 cycle after last frame byte; req drops 3 cycles after raw ack rises; reply 3 cycles after raw ack falls.
// Backpressure: tx_data/tx_valid held while tx_ready is low; rx bytes arriving outside IDLE/GET_* are dropped.
// Ports: sys_clk/sys_rst_n; rx_data/rx_valid (byte in); tx_data/tx_valid/tx_ready (byte out);
//   sd_addr/sd_wdata/sd_rdata, read_req/read_ack, write_req/write_ack (controller port); busy.
module uart_sdram_bridge #(
  parameter int unsigned TIMEOUT_CYC = 65535,
  parameter logic [7:0]  CMD_WR      = 8'h57,
  parameter logic [7:0]  CMD_RD      = 8'h52
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic [23:0] sd_addr,
  output logic [15:0] sd_wdata,
  input  logic [15:0] sd_rdata,
  output logic        read_req,
  input  logic        read_ack,
  output logic        write_req,
  input  logic        write_ack,
  output logic        busy
);

  typedef enum logic [2:0] {IDLE, GET_ADDR, GET_DATA, REQ, ACK_LOW, SEND} state_t;

  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYC - 1);

  state_t      state, state_nx;
  logic        is_wr;
  logic [1:0]  cnt;
  logic [15:0] tmo;
  logic        seen_low;   // ack observed low since entering REQ
  logic [1:0]  rack_sync;
  logic [1:0]  wack_sync;
  logic [7:0]  tx_lo;      // second reply byte (read low byte)
  logic        tx_more;    // another reply byte follows the current one

  logic ack_s;
  logic ack_hit;
  logic tmo_hit;
  logic is_cmd;

  assign ack_s   = is_wr ? wack_sync[1] : rack_sync[1];
  // A stale ack left over from a timed-out frame must fall before it counts.
  assign ack_hit = (state == REQ) && ack_s && seen_low;
  assign tmo_hit = (state == REQ) && !ack_hit && (tmo == TMO_LAST);
  assign is_cmd  = (rx_data == CMD_WR) || (rx_data == CMD_RD);

  assign read_req  = (state == REQ) && !is_wr;
  assign write_req = (state == REQ) && is_wr;
  assign tx_valid  = (state == SEND);
  assign busy      = (state != IDLE);

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:     if (rx_valid) state_nx = is_cmd ? GET_ADDR : SEND;
      GET_ADDR: if (rx_valid && cnt == 2'd2) state_nx = is_wr ? GET_DATA : REQ;
      GET_DATA: if (rx_valid && cnt == 2'd1) state_nx = REQ;
      REQ: begin
        if (ack_hit)      state_nx = ACK_LOW;
        else if (tmo_hit) state_nx = SEND;
      end
      ACK_LOW:  if (!ack_s) state_nx = SEND;
      SEND:     if (tx_ready && !tx_more) state_nx = IDLE;
      default:  state_nx = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state     <= IDLE;
      is_wr     <= 1'b0;
      cnt       <= 2'd0;
      tmo       <= 16'd0;
      seen_low  <= 1'b0;
      rack_sync <= 2'b00;
      wack_sync <= 2'b00;
      sd_addr   <= 24'd0;
      sd_wdata  <= 16'd0;
      tx_data   <= 8'd0;
      tx_lo     <= 8'd0;
      tx_more   <= 1'b0;
    end else begin
      state     <= state_nx;
      rack_sync <= {rack_sync[0], read_ack};
      wack_sync <= {wack_sync[0], write_ack};

      case (state)
        IDLE: if (rx_valid) begin
          cnt <= 2'd0;
          if (is_cmd) begin
            is_wr <= (rx_data == CMD_WR);
          end else begin
            tx_data <= 8'h3F;
            tx_more <= 1'b0;
          end
        end
        GET_ADDR: if (rx_valid) begin
          sd_addr <= {sd_addr[15:0], rx_data};
          cnt     <= (cnt == 2'd2) ? 2'd0 : cnt + 2'd1;
        end
        GET_DATA: if (rx_valid) begin
          sd_wdata <= {sd_wdata[7:0], rx_data};
          cnt      <= cnt + 2'd1;
        end
        REQ: begin
          tmo <= tmo + 16'd1;
          if (!ack_s) seen_low <= 1'b1;
          // Reply is staged at ack time; tx_valid stays low until SEND.
          if (ack_hit) begin
            tx_data <= is_wr ? 8'h4B : sd_rdata[15:8];
            tx_lo   <= sd_rdata[7:0];
            tx_more <= !is_wr;
          end else if (tmo_hit) begin
            tx_data <= 8'h54;
            tx_more <= 1'b0;
          end
        end
        SEND: if (tx_ready && tx_more) begin
          tx_data <= tx_lo;
          tx_more <= 1'b0;
        end
        default: ;
      endcase

      if (state != REQ && state_nx == REQ) begin
        tmo      <= 16'd0;
        seen_low <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_sdram_bridge.sv
module tb_uart_sdram_bridge;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b1;
  logic [23:0] sd_addr;
  logic [15:0] sd_wdata;
  logic [15:0] sd_rdata = 16'h0000;
  logic        read_req;
  logic        read_ack = 1'b0;
  logic        write_req;
  logic        write_ack = 1'b0;
  logic        busy;

  uart_sdram_bridge #(.TIMEOUT_CYC(16)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
    .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .sd_addr(sd_addr), .sd_wdata(sd_wdata), .sd_rdata(sd_rdata),
    .read_req(read_req), .read_ack(read_ack),
    .write_req(write_req), .write_ack(write_ack),
    .busy(busy)
  );

  always #5 sys_clk = ~sys_clk;

  int n_checks = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  // Bytes are packed MSB-first; one idle cycle between bytes, none after the last.
  task automatic send_frame(input logic [47:0] bytes, input int n);
    for (int i = 0; i < n; i++) begin
      rx_data  = bytes[47 - 8*i -: 8];
      rx_valid = 1'b1;
      tick();
      rx_valid = 1'b0;
      if (i < n - 1) tick();
    end
  endtask

  // Controller model: ack 4 cycles after entry, hold 4 cycles, then release.
  task automatic do_ack(input bit rd, input logic [15:0] rdata);
    logic [1:0] exp_req;
    exp_req = rd ? 2'b01 : 2'b10;
    chk("req_rise", {write_req, read_req}, exp_req);
    repeat (4) tick();
    chk("req_hold", {write_req, read_req}, exp_req);
    if (rd) begin read_ack = 1'b1; sd_rdata = rdata; end
    else write_ack = 1'b1;
    tick(); tick();
    chk("req_sync_wait", {write_req, read_req}, exp_req);
    tick();
    chk("req_fall_3cyc", {write_req, read_req}, 2'b00);
    tick();
    read_ack = 1'b0; write_ack = 1'b0; sd_rdata = 16'h0000;
    tick(); tick();
    chk("tx_before_acklow", tx_valid, 1'b0);
    tick();
    chk("tx_rise_3cyc", tx_valid, 1'b1);
  endtask

  task automatic expect_tx(input string name, input logic [7:0] b);
    int w = 0;
    while (!tx_valid && w < 40) begin tick(); w++; end
    chk({name, "_valid"}, tx_valid, 1'b1);
    chk(name, tx_data, b);
    tick();
  endtask

  typedef struct {
    logic [47:0] bytes;
    int          n;
    int          kind;    // 0 none, 1 write, 2 read
    logic [15:0] rdata;
    logic [23:0] addr;
    logic [15:0] wdata;
    logic [15:0] rep;     // reply bytes; single-byte reply in [7:0]
    int          nrep;
  } vec_t;

  vec_t vt[6];

  task automatic run_vec(input vec_t v);
    send_frame(v.bytes, v.n);
    if (v.kind == 0) begin
      chk("noreq", {write_req, read_req}, 2'b00);
    end else begin
      chk("addr", sd_addr, v.addr);
      if (v.kind == 1) chk("wdata", sd_wdata, v.wdata);
      do_ack(v.kind == 2, v.rdata);
    end
    if (v.nrep == 2) expect_tx("reply_hi", v.rep[15:8]);
    expect_tx("reply", v.rep[7:0]);
    chk("busy_end", busy, 1'b0);
    chk("tx_valid_end", tx_valid, 1'b0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
    $fatal(1);
  end

  initial begin
    int cyc;
    int bad;

    vt[0] = '{48'h57_00_12_34_AB_CD, 6, 1, 16'h0000, 24'h001234, 16'hABCD, 16'h004B, 1};
    vt[1] = '{48'h41_00_00_00_00_00, 1, 0, 16'h0000, 24'h000000, 16'h0000, 16'h003F, 1};
    vt[2] = '{48'h52_00_12_34_00_00, 4, 2, 16'hBEEF, 24'h001234, 16'h0000, 16'hBEEF, 2};
    vt[3] = '{48'h52_12_34_56_00_00, 4, 2, 16'h1234, 24'h123456, 16'h0000, 16'h1234, 2};
    vt[4] = '{48'h57_FF_FF_FF_00_01, 6, 1, 16'h0000, 24'hFFFFFF, 16'h0001, 16'h004B, 1};
    vt[5] = '{48'h00_00_00_00_00_00, 1, 0, 16'h0000, 24'h000000, 16'h0000, 16'h003F, 1};

    #1;
    chk("rst_tx", {tx_valid, tx_data}, 9'h000);
    chk("rst_req", {write_req, read_req, busy}, 3'b000);
    chk("rst_addr", sd_addr, 24'h0);
    chk("rst_wdata", sd_wdata, 16'h0);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    tick();

    for (int i = 0; i < 6; i++) run_vec(vt[i]);

    // Timeout: no ack, read_req drops 16 cycles after rising, reply 'T'.
    send_frame(48'h52_00_00_10_00_00, 4);
    chk("tmo_req", read_req, 1'b1);
    cyc = 0;
    while (read_req && cyc < 40) begin tick(); cyc++; end
    chk("tmo_cycles", cyc, 16);
    expect_tx("tmo_reply", 8'h54);
    chk("tmo_busy", busy, 1'b0);

    // Late ack still high when the next read reaches REQ: must be ignored until it falls.
    read_ack = 1'b1;
    tick(); tick();
    send_frame(48'h52_00_00_30_00_00, 4);
    repeat (3) tick();
    chk("stale_ack_ignored", read_req, 1'b1);
    read_ack = 1'b0;
    repeat (3) tick();
    do_ack(1'b1, 16'h5AA5);
    expect_tx("stale_hi", 8'h5A);
    expect_tx("stale_lo", 8'hA5);
    chk("stale_busy", busy, 1'b0);

    // Backpressure: stall 10 cycles on the first read byte; a stray rx byte is dropped.
    tx_ready = 1'b0;
    send_frame(48'h52_00_00_20_00_00, 4);
    do_ack(1'b1, 16'hBEEF);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      if (tx_data !== 8'hBE || tx_valid !== 1'b1) bad++;
      rx_valid = (i == 3);
      rx_data  = 8'h57;
      tick();
    end
    rx_valid = 1'b0;
    chk("stall_hold", bad, 0);
    tx_ready = 1'b1;
    chk("stall_first", tx_data, 8'hBE);
    tick();
    chk("stall_second", {tx_valid, tx_data}, 9'h1EF);
    tick();
    chk("stall_done", {tx_valid, busy}, 2'b00);

    // Asynchronous reset while write_req is high.
    send_frame(48'h57_00_00_05_11_22, 6);
    chk("pre_rst_wreq", write_req, 1'b1);
    tick();
    #2 sys_rst_n = 1'b0;
    #1;
    chk("arst_req", {write_req, read_req}, 2'b00);
    chk("arst_busy", {busy, tx_valid}, 2'b00);
    chk("arst_addr", sd_addr, 24'h0);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    tick();
    run_vec(vt[0]);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
